// File: rtl/hdmi_video_timing_gen_pkg.sv
// Shared HDMI video configuration types, standard timing constants and helpers
// used by the video timing generator.
package hdmi_video_timing_gen_pkg;

  localparam int HDMI_CFG_W = 12;

  // Sync polarity encoding: 1 = active-high pulse.
  localparam logic HSYNC_POL_POS = 1'b1;
  localparam logic VSYNC_POL_POS = 1'b1;

  typedef struct packed {
    logic [HDMI_CFG_W-1:0] h_visible;
    logic [HDMI_CFG_W-1:0] h_sync_start;
    logic [HDMI_CFG_W-1:0] h_sync_end;
    logic [HDMI_CFG_W-1:0] h_total;
    logic [HDMI_CFG_W-1:0] v_visible;
    logic [HDMI_CFG_W-1:0] v_sync_start;
    logic [HDMI_CFG_W-1:0] v_sync_end;
    logic [HDMI_CFG_W-1:0] v_total;
    logic                  h_sync_pol;
    logic                  v_sync_pol;
  } HDMIVideoConfig;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_APPLY,
    ST_SETTLE
  } vtg_state_e;

  localparam HDMIVideoConfig HDMI_VIDEO_CONFIG_1080P = '{
    h_visible: 12'd1920, h_sync_start: 12'd2008, h_sync_end: 12'd2052, h_total: 12'd2200,
    v_visible: 12'd1080, v_sync_start: 12'd1084, v_sync_end: 12'd1089, v_total: 12'd1125,
    h_sync_pol: HSYNC_POL_POS, v_sync_pol: VSYNC_POL_POS};

  localparam HDMIVideoConfig HDMI_VIDEO_CONFIG_960P = '{
    h_visible: 12'd1280, h_sync_start: 12'd1376, h_sync_end: 12'd1488, h_total: 12'd1800,
    v_visible: 12'd960,  v_sync_start: 12'd961,  v_sync_end: 12'd964,  v_total: 12'd1000,
    h_sync_pol: HSYNC_POL_POS, v_sync_pol: VSYNC_POL_POS};

  localparam HDMIVideoConfig HDMI_VIDEO_CONFIG_480P = '{
    h_visible: 12'd720, h_sync_start: 12'd736, h_sync_end: 12'd798, h_total: 12'd858,
    v_visible: 12'd480, v_sync_start: 12'd489, v_sync_end: 12'd495, v_total: 12'd525,
    h_sync_pol: ~HSYNC_POL_POS, v_sync_pol: ~VSYNC_POL_POS};

  localparam HDMIVideoConfig HDMI_VIDEO_CONFIG_VGA = '{
    h_visible: 12'd640, h_sync_start: 12'd656, h_sync_end: 12'd752, h_total: 12'd800,
    v_visible: 12'd480, v_sync_start: 12'd490, v_sync_end: 12'd492, v_total: 12'd525,
    h_sync_pol: ~HSYNC_POL_POS, v_sync_pol: ~VSYNC_POL_POS};

  // Totals below 2 would make the end-of-line/end-of-frame compare meaningless.
  function automatic logic cfg_degenerate(input HDMIVideoConfig c);
    return (c.h_total < HDMI_CFG_W'(2)) || (c.v_total < HDMI_CFG_W'(2));
  endfunction

endpackage

// File: rtl/hdmi_raster_counter.sv
// Free-running x/y raster counters with wrap at the programmed totals and a
// synchronous restart to (0,0).
module hdmi_raster_counter #(
  parameter int CW = 12
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [CW-1:0] h_total,
  input  logic [CW-1:0] v_total,
  input  logic          restart,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          eol,
  output logic          eof
);

  localparam logic [CW-1:0] ONE = CW'(1);

  assign eol = (x == h_total - ONE);
  assign eof = eol && (y == v_total - ONE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x <= '0;
      y <= '0;
    end else if (restart || eof) begin
      x <= '0;
      y <= '0;
    end else if (eol) begin
      x <= '0;
      y <= y + ONE;
    end else begin
      x <= x + ONE;
    end
  end

endmodule

// File: rtl/hdmi_video_timing_gen.sv
// HDMI raster timing generator: sync/DE/position outputs, with configuration
// changes applied only at frame boundaries followed by a DE-blanked settle period.
module hdmi_video_timing_gen
  import hdmi_video_timing_gen_pkg::*;
#(
  parameter int             SETTLE_FRAMES = 2,
  parameter int             CW            = HDMI_CFG_W,
  parameter HDMIVideoConfig INIT_CONFIG   = HDMI_VIDEO_CONFIG_1080P
) (
  input  logic           clock,
  input  logic           reset,
  input  HDMIVideoConfig hdmiVideoConfig,
  input  logic           r2v_f,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic [CW-1:0]  pixel_x,
  output logic [CW-1:0]  pixel_y,
  output logic           frame_start,
  output logic           config_applied,
  output logic           r2v_f_active,
  output logic           locked
);

  localparam int             SW          = $clog2(SETTLE_FRAMES + 2);
  localparam logic [SW-1:0]  SETTLE_INIT = SW'(SETTLE_FRAMES);
  localparam logic [SW-1:0]  S_ONE       = SW'(1);

  HDMIVideoConfig active_cfg, pend_cfg;
  logic           pend_r2v;
  vtg_state_e     state, state_d;
  logic [SW-1:0]  settle_cnt, settle_d;
  logic           locked_d, apply, cfg_diff, sof;
  logic [CW-1:0]  x, y;
  logic           eol, eof;

  hdmi_raster_counter #(.CW(CW)) u_raster (
    .clock   (clock),
    .reset   (reset),
    .h_total (CW'(active_cfg.h_total)),
    .v_total (CW'(active_cfg.v_total)),
    .restart (apply),
    .x       (x),
    .y       (y),
    .eol     (eol),
    .eof     (eof)
  );

  assign cfg_diff = (pend_cfg != active_cfg) || (pend_r2v != r2v_f_active);
  assign sof      = (x == '0) && (y == '0);

  // Apply is taken on the end-of-frame edge itself, so the natural wrap and the
  // restart coincide and the new frame begins without a repeated (0,0) pixel.
  always_comb begin
    state_d  = state;
    locked_d = locked;
    settle_d = settle_cnt;
    apply    = 1'b0;
    case (state)
      ST_IDLE:  if (cfg_diff) state_d = ST_ARMED;
      ST_ARMED: begin
        if (!cfg_diff)  state_d = ST_IDLE;
        else if (eof)   apply   = 1'b1;
      end
      ST_APPLY: state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (cfg_diff && eof) apply = 1'b1;
        else if (sof) begin
          if (settle_cnt <= S_ONE) begin
            settle_d = '0;
            locked_d = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            settle_d = settle_cnt - S_ONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (apply) begin
      state_d  = ST_APPLY;
      locked_d = 1'b0;
      settle_d = SETTLE_INIT;
    end
  end

  // Reset behaves as an apply of the init config: the first frame after release
  // is not counted, so SETTLE_FRAMES full frames stay blanked.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= ST_APPLY;
      locked         <= 1'b0;
      settle_cnt     <= SETTLE_INIT;
      config_applied <= 1'b0;
      active_cfg     <= INIT_CONFIG;
      r2v_f_active   <= 1'b1;
      pend_cfg       <= INIT_CONFIG;
      pend_r2v       <= 1'b1;
    end else begin
      state          <= state_d;
      locked         <= locked_d;
      settle_cnt     <= settle_d;
      config_applied <= apply;
      if (apply) begin
        active_cfg   <= pend_cfg;
        r2v_f_active <= pend_r2v;
      end
      if (!cfg_degenerate(hdmiVideoConfig)) begin
        pend_cfg <= hdmiVideoConfig;
        pend_r2v <= r2v_f;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hsync       <= ~INIT_CONFIG.h_sync_pol;
      vsync       <= ~INIT_CONFIG.v_sync_pol;
      de          <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= ((x >= CW'(active_cfg.h_sync_start)) && (x < CW'(active_cfg.h_sync_end)))
                     ? active_cfg.h_sync_pol : ~active_cfg.h_sync_pol;
      vsync       <= ((y >= CW'(active_cfg.v_sync_start)) && (y < CW'(active_cfg.v_sync_end)))
                     ? active_cfg.v_sync_pol : ~active_cfg.v_sync_pol;
      de          <= (x < CW'(active_cfg.h_visible)) && (y < CW'(active_cfg.v_visible)) && locked_d;
      pixel_x     <= x;
      pixel_y     <= y;
      frame_start <= sof;
    end
  end

endmodule

// File: tb/tb_hdmi_video_timing_gen.sv
// Directed bench: a 1080P instance for reset/first-line timing and a small-raster
// instance for the config-change state machine, settle, reject and reset cases.
module tb_hdmi_video_timing_gen;
  import hdmi_video_timing_gen_pkg::*;

  localparam HDMIVideoConfig T0 = '{
    h_visible: 12'd12, h_sync_start: 12'd14, h_sync_end: 12'd17, h_total: 12'd20,
    v_visible: 12'd6,  v_sync_start: 12'd7,  v_sync_end: 12'd8,  v_total: 12'd10,
    h_sync_pol: 1'b1, v_sync_pol: 1'b1};
  localparam HDMIVideoConfig T1 = '{
    h_visible: 12'd10, h_sync_start: 12'd11, h_sync_end: 12'd13, h_total: 12'd16,
    v_visible: 12'd5,  v_sync_start: 12'd6,  v_sync_end: 12'd7,  v_total: 12'd8,
    h_sync_pol: 1'b0, v_sync_pol: 1'b0};
  localparam HDMIVideoConfig T2 = '{
    h_visible: 12'd8, h_sync_start: 12'd9, h_sync_end: 12'd11, h_total: 12'd12,
    v_visible: 12'd4, v_sync_start: 12'd4, v_sync_end: 12'd5,  v_total: 12'd6,
    h_sync_pol: 1'b1, v_sync_pol: 1'b1};

  logic clock = 1'b0;
  logic reset;
  HDMIVideoConfig cfg_a, cfg_b;
  logic r2v_a, r2v_b;
  logic a_hs, a_vs, a_de, a_fs, a_app, a_r2v, a_lk;
  logic b_hs, b_vs, b_de, b_fs, b_app, b_r2v, b_lk;
  logic [11:0] a_px, a_py, b_px, b_py;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  hdmi_video_timing_gen u_a (
    .clock(clock), .reset(reset), .hdmiVideoConfig(cfg_a), .r2v_f(r2v_a),
    .hsync(a_hs), .vsync(a_vs), .de(a_de), .pixel_x(a_px), .pixel_y(a_py),
    .frame_start(a_fs), .config_applied(a_app), .r2v_f_active(a_r2v), .locked(a_lk));

  hdmi_video_timing_gen #(.INIT_CONFIG(T0)) u_b (
    .clock(clock), .reset(reset), .hdmiVideoConfig(cfg_b), .r2v_f(r2v_b),
    .hsync(b_hs), .vsync(b_vs), .de(b_de), .pixel_x(b_px), .pixel_y(b_py),
    .frame_start(b_fs), .config_applied(b_app), .r2v_f_active(b_r2v), .locked(b_lk));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, hs_cnt, fs_cnt, de_cnt, app_cnt, lk_lo, hs_first;
    reset = 1'b0;
    cfg_a = HDMI_VIDEO_CONFIG_1080P; r2v_a = 1'b1;
    cfg_b = T0; r2v_b = 1'b1;
    step(3);

    // 1080P reset state
    chk("a_rst_hsync", a_hs, 0);
    chk("a_rst_vsync", a_vs, 0);
    chk("a_rst_de", a_de, 0);
    chk("a_rst_locked", a_lk, 0);
    chk("a_rst_fs", a_fs, 0);
    chk("a_rst_r2v", a_r2v, 1);
    chk("a_rst_px", a_px, 0);
    reset = 1'b1;
    step(1);
    chk("a_fs_clk1", a_fs, 1);
    chk("a_px_clk1", a_px, 0);

    // First 1080P line: hsync width/position, no DE, no second frame_start
    hs_cnt = 0; fs_cnt = 0; de_cnt = 0; hs_first = -1;
    for (int i = 0; i < 2200; i++) begin
      step(1);
      if (a_hs) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(a_px);
      end
      if (a_fs) fs_cnt++;
      if (a_de) de_cnt++;
    end
    chk("a_hsync_width", hs_cnt, 44);
    chk("a_hsync_start", hs_first, 2008);
    chk("a_fs_line", fs_cnt, 0);
    chk("a_de_unlocked", de_cnt, 0);
    chk("a_line_y", a_py, 1);
    chk("a_line_x", a_px, 0);

    // Small raster: settle of two full frames after reset
    reset = 1'b0;
    step(2);
    chk("b_rst_hsync", b_hs, 0);
    reset = 1'b1;
    de_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      step(1);
      if (b_de) de_cnt++;
    end
    chk("b_settle_de", de_cnt, 0);
    chk("b_settle_locked", b_lk, 0);
    step(1);
    chk("b_lock", b_lk, 1);
    chk("b_lock_de", b_de, 1);
    chk("b_lock_fs", b_fs, 1);

    // Mid-frame switch T0 -> T1 with r2v 1 -> 0: applied at end of frame
    step(50);
    cfg_b = T1; r2v_b = 1'b0;
    n = 0;
    while (!b_app && n < 1000) begin step(1); n++; end
    chk("b_apply_lat", n, 149);
    chk("b_apply_r2v", b_r2v, 0);
    step(1);
    chk("b_new_px", b_px, 0);
    chk("b_new_fs", b_fs, 1);
    chk("b_new_locked", b_lk, 0);
    chk("b_new_hs_idle", b_hs, 1);
    chk("b_app_once", b_app, 0);
    hs_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      if (!b_hs) hs_cnt++;
    end
    chk("b_t1_hs_low", hs_cnt, 2);
    chk("b_t1_line_x", b_px, 0);
    chk("b_t1_line_y", b_py, 1);

    // Change T1 -> T2 in the second settle frame: settle restarts
    step(123);
    cfg_b = T2;
    n = 0;
    while (!b_app && n < 1000) begin step(1); n++; end
    chk("b_settle_apply_lat", n, 116);
    step(144);
    chk("b_resettle_locked", b_lk, 0);
    step(1);
    chk("b_relock", b_lk, 1);
    chk("b_relock_de", b_de, 1);

    // Toggle T2 -> T0 -> T2 within one frame: nothing applied
    cfg_b = T0;
    step(5);
    cfg_b = T2;
    app_cnt = 0; fs_cnt = 0; lk_lo = 0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (b_app) app_cnt++;
      if (b_fs) fs_cnt++;
      if (!b_lk) lk_lo++;
    end
    chk("b_toggle_apply", app_cnt, 0);
    chk("b_toggle_fs", fs_cnt, 2);
    chk("b_toggle_locked", lk_lo, 0);

    // Degenerate h_total rejected
    cfg_b = T2; cfg_b.h_total = 12'd1; r2v_b = 1'b1;
    app_cnt = 0; fs_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (b_app) app_cnt++;
      if (b_fs) fs_cnt++;
    end
    chk("b_degen_apply", app_cnt, 0);
    chk("b_degen_fs", fs_cnt, 3);
    chk("b_degen_r2v", b_r2v, 0);
    cfg_b = T2; r2v_b = 1'b0;

    // Asynchronous reset mid-frame
    n = 0;
    while (!(b_px == 12'd5 && b_py == 12'd3) && n < 200) begin step(1); n++; end
    chk("b_mid_found", (n < 200), 1);
    reset = 1'b0;
    #1;
    chk("b_arst_px", b_px, 0);
    chk("b_arst_py", b_py, 0);
    chk("b_arst_locked", b_lk, 0);
    chk("b_arst_de", b_de, 0);
    chk("b_arst_r2v", b_r2v, 1);
    chk("b_arst_hs", b_hs, 0);
    step(2);
    reset = 1'b1;
    step(1);
    chk("b_rel_fs", b_fs, 1);
    chk("b_rel_px0", b_px, 0);
    step(1);
    chk("b_rel_px1", b_px, 1);
    chk("b_rel_py", b_py, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hdmi_video_timing_gen.md
Name: hdmi_video_timing_gen

Overview:
- Downstream consumer of the HDMI video configuration word and `r2v_f` flag.
- Generates raster counters, HSYNC/VSYNC and DE for the HDMI transmitter and the line-buffer read side.
- Accepts configuration changes only at a frame boundary, then blanks DE for a settle period so the transmitter never sees a torn frame.

Parameters:
- `SETTLE_FRAMES`, 2: number of full frames with DE forced low after a configuration is applied.
- `CW`, 12: width of the horizontal and vertical counters and timing fields.

Ports:
- `clock`  in  1  pixel clock.
- `reset`  in  1  asynchronous reset, active-low.
- `hdmiVideoConfig`  in  HDMIVideoConfig  requested timing, already registered in the `clock` domain.
- `r2v_f`  in  1  requested line-doubling flag, paired with `hdmiVideoConfig`.
- `hsync`  out  1  horizontal sync, driven at the configured polarity.
- `vsync`  out  1  vertical sync, driven at the configured polarity.
- `de`  out  1  data enable.
- `pixel_x`  out  CW  horizontal position, aligned with `de`.
- `pixel_y`  out  CW  vertical position, aligned with `de`.
- `frame_start`  out  1  one-cycle pulse, aligned with pixel (0,0).
- `config_applied`  out  1  one-cycle pulse on the cycle a new configuration takes effect.
- `r2v_f_active`  out  1  line-doubling flag belonging to the active configuration.
- `locked`  out  1  high once the settle period has elapsed.

Behaviour:
- Fields used from HDMIVideoConfig, each CW bits: `h_visible`, `h_sync_start`, `h_sync_end`, `h_total`, `v_visible`, `v_sync_start`, `v_sync_end`, `v_total`; plus 1-bit `h_sync_pol` and `v_sync_pol`.
- Reset state (reset low):
  - active config = 1080P constant; `r2v_f_active` = 1.
  - internal x, y = 0; `pixel_x`, `pixel_y` = 0.
  - `hsync` = ~`h_sync_pol`; `vsync` = ~`v_sync_pol` of the 1080P config.
  - `de`, `frame_start`, `config_applied`, `locked` = 0; settle counter = `SETTLE_FRAMES`.
- Counters:
  - x increments every clock and wraps to 0 at `h_total`-1.
  - On the x wrap, y increments and wraps to 0 at `v_total`-1.
  - All counter arithmetic is unsigned CW-bit.
- Outputs are registered from the current x, y with exactly 1 clock latency:
  - `hsync` active while `h_sync_start` <= x < `h_sync_end`.
  - `vsync` active while `v_sync_start` <= y < `v_sync_end`.
  - `de` = x < `h_visible` && y < `v_visible` && `locked`.
- Pending-config state machine:
  - IDLE: a pending register continuously samples the inputs. If the pending config or pending `r2v_f` differs from the active value, go to ARMED.
  - ARMED: the pending register keeps tracking the inputs, so the last value wins. If the inputs return to the active value, go back to IDLE without applying. At end of frame (x = `h_total`-1 and y = `v_total`-1), go to APPLY.
  - APPLY (single cycle): copy pending to active; x and y restart at 0 using the new totals; pulse `config_applied`; `locked` = 0; settle counter = `SETTLE_FRAMES`; go to SETTLE.
  - SETTLE: decrement the settle counter on each `frame_start`. At 0, set `locked` = 1 and go to IDLE.
  - A further input change during SETTLE is captured as pending. It is applied at the next end of frame, and the settle counter restarts.
- `frame_start` pulses on every frame, including the first frame after APPLY.
- Guard for degenerate configs: if `h_total` < 2 or `v_total` < 2, the pending config is rejected and the FSM stays in its current state.
- Reset asserted mid-frame: all state returns immediately to the reset values. After release, counting starts at (0,0) on the next clock.
- Simultaneous input change and end of frame in IDLE: the change is not applied in that frame. It waits for the following end of frame (one-frame minimum apply latency).

Decomposition:
- The HDMIVideoConfig typedef and all `HDMI_VIDEO_CONFIG_*` constants stay in the shared hdmi config package.
- Add package constants `HSYNC_POL_POS` and `VSYNC_POL_POS`.
- One natural sub-module, `hdmi_raster_counter`: x/y counters with wrap and end-of-frame flag, with totals and a synchronous restart as inputs.

Test Plan:
- Reset release with 1080P input (2200x1125, hsync 2008..2052, vsync 1084..1089, positive polarity):
  - `frame_start` at clock 1 and again 2,475,000 clocks later.
  - `hsync` high for 44 clocks per line.
  - `de` stays low for 2 frames, then `locked` = 1.
- Switch to 480P (858x525, hsync 736..798, vsync 489..495, negative polarity) at mid-frame:
  - no change until the 1080P end of frame.
  - `config_applied` pulses then; the next line period is 858 clocks; `hsync` is low for 62 clocks.
  - `r2v_f_active` goes 1 -> 0 on the same cycle.
- Toggle the input 1080P -> 960P -> 1080P within one frame: no `config_applied`, `locked` stays 1, timing unchanged.
- Change 480P -> VGA during SETTLE: VGA is applied at the next end of frame, and `locked` stays low for 2 further frames.
- Assert reset at x=500, y=300: all outputs take their reset values asynchronously, and counting restarts at (0,0) on release.
- Inject `h_total` = 1: rejected; the active timing is unchanged and no `config_applied` pulse occurs.
